// File: rtl/pipeline_hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath (master) drives stage information; the controller (slave) returns stall/flush/forward controls.
interface pipeline_hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic             ex_memread;
  logic [4:0]       ex_wreg;
  logic             br_taken;
  logic             mem_regwrite;
  logic             mem_memread;
  logic             mem_memwrite;
  logic [4:0]       mem_wreg;
  logic             wb_regwrite;
  logic [4:0]       wb_wreg;
  logic             dmem_ready;
  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             stall_exmem;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_memwb;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_memread, ex_wreg,
           br_taken, mem_regwrite, mem_memread, mem_memwrite, mem_wreg,
           wb_regwrite, wb_wreg, dmem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           flush_memwb, fwd_a, fwd_b, bus_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_memread, ex_wreg,
           br_taken, mem_regwrite, mem_memread, mem_memwrite, mem_wreg,
           wb_regwrite, wb_wreg, dmem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           flush_memwb, fwd_a, fwd_b, bus_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX forwarding, load-use stall, branch flush,
// and whole-pipe freeze while data memory stalls, with a timeout into a sticky bus error.
//
//   state     | meaning
//   RUN       | normal flow; a not-ready memory access freezes this cycle and enters MEM_WAIT
//   MEM_WAIT  | access outstanding; freeze until dmem_ready, error after MEM_TIMEOUT frozen cycles
//   ERR       | memory timed out; pipe frozen until reset, bus_err held
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         reset,
  pipeline_hazard_if.slave hz
);
  // wait_cnt only ever needs to reach MEM_TIMEOUT-1
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       mem_access;
  logic       freeze;
  logic       load_use;
  logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic       flush_ifid, flush_idex, flush_memwb;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_rw,
    input logic       mem_mr,
    input logic [4:0] mem_wr,
    input logic       wb_rw,
    input logic [4:0] wb_wr
  );
    // a load in MEM has no ALU result to forward yet
    if (mem_rw && !mem_mr && (mem_wr != 5'd0) && (mem_wr == src)) return 2'b10;
    if (wb_rw && (wb_wr != 5'd0) && (wb_wr == src))                return 2'b01;
    return 2'b00;
  endfunction

  assign mem_access = hz.mem_memread | hz.mem_memwrite;

  assign freeze = ((state_q == ST_RUN) && mem_access && !hz.dmem_ready) ||
                  ((state_q == ST_MEM_WAIT) && !hz.dmem_ready) ||
                  (state_q == ST_ERR);

  assign load_use = hz.ex_memread && (hz.ex_wreg != 5'd0) &&
                    ((hz.id_use_rs && (hz.id_rs == hz.ex_wreg)) ||
                     (hz.id_use_rt && (hz.id_rt == hz.ex_wreg)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_access && !hz.dmem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        bus_err_d = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (reset) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_memwb = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.ex_rs, hz.mem_regwrite, hz.mem_memread, hz.mem_wreg,
                      hz.wb_regwrite, hz.wb_wreg);
      fwd_b = fwd_sel(hz.ex_rt, hz.mem_regwrite, hz.mem_memread, hz.mem_wreg,
                      hz.wb_regwrite, hz.wb_wreg);
      if (freeze) begin
        // a taken branch simply waits in EX until the freeze lifts
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (hz.br_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (stall_pc && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_pc    = stall_pc;
  assign hz.stall_ifid  = stall_ifid;
  assign hz.stall_idex  = stall_idex;
  assign hz.stall_exmem = stall_exmem;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.flush_idex  = flush_idex;
  assign hz.flush_memwb = flush_memwb;
  assign hz.fwd_a       = fwd_a;
  assign hz.fwd_b       = fwd_b;
  assign hz.bus_err     = bus_err_q;
  assign hz.stall_cnt   = stall_cnt_q;
endmodule
